// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback per instruction.
// Memory states last MEM_LAT cycles; outputs are decoded from the current state (BRANCH also from zero).
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int MEM_LAT  = 1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                pcWrite,
    output logic [1:0]          pcSrc,
    output logic                iorD,
    output logic                irWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic                memToReg,
    output logic                regDest,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] LAST_BEAT = WAIT_W'(MEM_LAT - 1);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  retired_q;
    logic              last_beat;
    logic              mem_state;
    logic              retire;

    assign last_beat = (wait_q == LAST_BEAT);
    assign mem_state = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR});
    assign retire    = (state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_ILLEGAL})
                     || ((state_q == S_MEM_WR) && last_beat);
    assign retired   = retired_q;
    assign state     = state_q;

    // Wait counter falls back to 0 on the last beat, so every memory state is entered with it cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= (mem_state && !last_beat) ? wait_q + WAIT_W'(1) : '0;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (last_beat) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (last_beat) state_d = S_WB_MEM;
            S_MEM_WR:   if (last_beat) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcWrite  = 1'b0;
        pcSrc    = 2'b00;
        iorD     = 1'b0;
        irWrite  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        regDest  = 1'b0;
        regWrite = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        aluOp    = '0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = last_beat;
                    pcWrite = last_beat;
                end
                S_DECODE:   aluSrcB = 2'b11;
                S_EXEC_R: begin
                    aluSrcA = 1'b1;
                    aluOp   = ALUOP_W'(2'b10);
                end
                S_WB_R: begin
                    regDest  = 1'b1;
                    regWrite = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_WB_I:     regWrite = 1'b1;
                S_MEM_RD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                S_WB_MEM: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEM_WR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA = 1'b1;
                    aluOp   = ALUOP_W'(2'b01);
                    pcSrc   = 2'b01;
                    pcWrite = (opcode == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pcSrc   = 2'b10;
                    pcWrite = 1'b1;
                end
                S_ILLEGAL:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances (MEM_LAT=1, MEM_LAT=3, 2-bit counter) checked cycle by cycle.
module tb_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_WB_R = 3, S_EXEC_I = 4, S_WB_I = 5;
    localparam int S_MEM_ADDR = 6, S_MEM_RD = 7, S_WB_MEM = 8, S_MEM_WR = 9, S_BRANCH = 10;
    localparam int S_JUMP = 11, S_ILLEGAL = 12;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw;
        logic [1:0]  pcs;
        logic        iord, irw, mrd, mwr, m2r, rdst, rw, asa;
        logic [1:0]  asb;
        logic [1:0]  aop;
        logic        ill;
        logic [31:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst [3];
    logic [5:0] op  [3];
    logic       z   [3];
    exp_t       obs [3];

    exp_t        q[$];
    exp_t        mon_e;
    int          cur = 0;
    int          lat = 1;
    int          plen;
    logic [31:0] mcnt = '0;
    logic [31:0] mmask = 32'hFFFF_FFFF;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L  = (g == 1) ? 3 : 1;
        localparam int CW = (g == 2) ? 2 : 32;
        logic [3:0]    st;
        logic          pcw, iord, irw, mrd, mwr, m2r, rdst, rw, asa, ill;
        logic [1:0]    pcs, asb, aop;
        logic [CW-1:0] ret;

        multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .MEM_LAT(L), .CNT_W(CW)) u_dut (
            .clk(clk), .reset(rst[g]), .opcode(op[g]), .zero(z[g]),
            .pcWrite(pcw), .pcSrc(pcs), .iorD(iord), .irWrite(irw), .memRead(mrd),
            .memWrite(mwr), .memToReg(m2r), .regDest(rdst), .regWrite(rw),
            .aluSrcA(asa), .aluSrcB(asb), .aluOp(aop), .illegal(ill),
            .retired(ret), .state(st)
        );

        assign obs[g] = {st, pcw, pcs, iord, irw, mrd, mwr, m2r, rdst, rw, asa, asb, aop, ill, 32'(ret)};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected control word for one cycle of a state; fl is the "last fetch beat" or branch-taken flag.
    function automatic exp_t ctl(input int s, input logic fl, input logic [31:0] r);
        exp_t e;
        e = '0;
        e.st = 4'(s);
        e.ret = r;
        case (s)
            S_FETCH:    begin e.mrd = 1; e.asb = 2'b01; e.irw = fl; e.pcw = fl; end
            S_DECODE:   e.asb = 2'b11;
            S_EXEC_R:   begin e.asa = 1; e.asb = 2'b00; e.aop = 2'b10; end
            S_WB_R:     begin e.rdst = 1; e.rw = 1; end
            S_EXEC_I:   begin e.asa = 1; e.asb = 2'b10; end
            S_WB_I:     e.rw = 1;
            S_MEM_ADDR: begin e.asa = 1; e.asb = 2'b10; end
            S_MEM_RD:   begin e.mrd = 1; e.iord = 1; end
            S_WB_MEM:   begin e.m2r = 1; e.rw = 1; end
            S_MEM_WR:   begin e.mwr = 1; e.iord = 1; end
            S_BRANCH:   begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pcw = fl; end
            S_JUMP:     begin e.pcs = 2'b10; e.pcw = 1; end
            S_ILLEGAL:  e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t in_reset(input int s, input logic [31:0] r);
        exp_t e;
        e = '0;
        e.st = 4'(s);
        e.ret = r;
        return e;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk($sformatf("dut%0d_cycle", cur), 64'(obs[cur]), 64'(mon_e));
        end
    end

    task automatic put(input int s, input logic fl);
        q.push_back(ctl(s, fl, mcnt));
        plen++;
    endtask

    task automatic do_reset(input int d, input int l, input logic [31:0] mask);
        cur = d;
        lat = l;
        mmask = mask;
        rst[d] = 1'b1;
        @(posedge clk); #1;
        q.push_back(in_reset(S_FETCH, 32'd0));
        @(posedge clk); #1;
        rst[d] = 1'b0;
        mcnt = '0;
    endtask

    task automatic issue(input logic [5:0] o, input logic zz);
        plen = 0;
        op[cur] = o;
        z[cur] = zz;
        for (int k = 0; k < lat; k++) put(S_FETCH, k == lat - 1);
        put(S_DECODE, 1'b0);
        case (o)
            6'h00: begin put(S_EXEC_R, 1'b0); put(S_WB_R, 1'b0); end
            6'h08: begin put(S_EXEC_I, 1'b0); put(S_WB_I, 1'b0); end
            6'h23: begin
                put(S_MEM_ADDR, 1'b0);
                for (int k = 0; k < lat; k++) put(S_MEM_RD, 1'b0);
                put(S_WB_MEM, 1'b0);
            end
            6'h2B: begin
                put(S_MEM_ADDR, 1'b0);
                for (int k = 0; k < lat; k++) put(S_MEM_WR, 1'b0);
            end
            6'h04:   put(S_BRANCH, zz);
            6'h05:   put(S_BRANCH, !zz);
            6'h02:   put(S_JUMP, 1'b0);
            default: put(S_ILLEGAL, 1'b0);
        endcase
        repeat (plen) @(posedge clk);
        #1;
        mcnt = (mcnt + 32'd1) & mmask;
        chk($sformatf("retired_after_%h", o), 64'(obs[cur].ret), 64'(mcnt));
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            op[d] = 6'h00;
            z[d] = 1'b0;
        end

        // MEM_LAT = 1: every instruction class and both branch polarities.
        do_reset(0, 1, 32'hFFFF_FFFF);
        issue(6'h00, 1'b0);
        issue(6'h08, 1'b0);
        issue(6'h23, 1'b0);
        issue(6'h2B, 1'b0);
        issue(6'h04, 1'b1);
        issue(6'h04, 1'b0);
        issue(6'h05, 1'b0);
        issue(6'h05, 1'b1);
        issue(6'h02, 1'b0);
        issue(6'h3F, 1'b0);
        issue(6'h01, 1'b0);
        issue(6'h00, 1'b0);

        // MEM_LAT = 3: stretched fetch and memory phases, then a reset inside MEM_RD.
        do_reset(1, 3, 32'hFFFF_FFFF);
        issue(6'h23, 1'b0);
        issue(6'h2B, 1'b0);
        issue(6'h00, 1'b0);
        issue(6'h05, 1'b0);
        plen = 0;
        op[1] = 6'h23;
        for (int k = 0; k < 3; k++) put(S_FETCH, k == 2);
        put(S_DECODE, 1'b0);
        put(S_MEM_ADDR, 1'b0);
        put(S_MEM_RD, 1'b0);
        repeat (plen) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        q.push_back(in_reset(S_MEM_RD, mcnt));
        @(posedge clk); #1;
        q.push_back(in_reset(S_FETCH, 32'd0));
        @(posedge clk); #1;
        rst[1] = 1'b0;
        mcnt = '0;
        chk("abort_retired", 64'(obs[1].ret), 64'd0);
        issue(6'h08, 1'b0);

        // 2-bit counter: fourth retirement wraps to zero.
        do_reset(2, 1, 32'h0000_0003);
        issue(6'h02, 1'b0);
        issue(6'h02, 1'b0);
        issue(6'h02, 1'b0);
        issue(6'h02, 1'b0);
        issue(6'h08, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
